// File: rtl/sram_like_arbiter_if.sv
// Bundles for the SRAM-like request/response ports: a read-only fetch port and
// a full command port that serves both the data requester and the memory side.
interface sram_like_arbiter_rd_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, addr, input addr_ok, data_ok, rdata);
  modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between fetch and data requesters, one
// transaction at a time, data-first with a bounded starvation guard for fetch.
module sram_like_arbiter #(
  parameter logic [3:0] STARVE_MAX = 4'd3
) (
  input  logic                         clk,
  input  logic                         resetn,
  sram_like_arbiter_rd_if.slave        inst,
  sram_like_arbiter_if.slave           data,
  sram_like_arbiter_if.master          mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_mem_req;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_starve_cnt;

  state_t      w_next_state;
  logic        w_grant_inst;
  logic        w_grant_data;
  logic        w_inst_data_ok;
  logic        w_data_data_ok;

  // Grant selection and next-state decode; grants are gated by resetn so
  // no accept can leak out while the block is held in reset.
  always_comb begin
    w_next_state   = r_state;
    w_grant_inst   = 1'b0;
    w_grant_data   = 1'b0;
    w_inst_data_ok = 1'b0;
    w_data_data_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (resetn && inst.req && data.req) begin
          if (r_starve_cnt == STARVE_MAX) begin
            w_grant_inst = 1'b1;
          end else begin
            w_grant_data = 1'b1;
          end
        end else if (resetn && inst.req) begin
          w_grant_inst = 1'b1;
        end else if (resetn && data.req) begin
          w_grant_data = 1'b1;
        end else begin
          w_grant_inst = 1'b0;
        end
        if (w_grant_inst || w_grant_data) begin
          w_next_state = S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem.addr_ok) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem.data_ok) begin
          w_next_state   = S_IDLE;
          w_inst_data_ok = ~r_owner;
          w_data_data_ok = r_owner;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, latched command and starvation counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_wstrb      <= 4'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state   <= w_next_state;
      r_mem_req <= (w_next_state == S_REQ);
      if (w_grant_inst) begin
        r_owner      <= 1'b0;
        r_wr         <= 1'b0;
        r_size       <= 2'd2;
        r_wstrb      <= 4'd0;
        r_addr       <= inst.addr;
        r_wdata      <= 32'd0;
        r_starve_cnt <= 4'd0;
      end else if (w_grant_data) begin
        r_owner <= 1'b1;
        r_wr    <= data.wr;
        r_size  <= data.size;
        r_wstrb <= data.wstrb;
        r_addr  <= data.addr;
        r_wdata <= data.wdata;
        // Count only data wins that actually held fetch off.
        if (inst.req) begin
          if (r_starve_cnt != 4'd15) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
          end
        end else begin
          r_starve_cnt <= 4'd0;
        end
      end
    end
  end

  assign inst.addr_ok = w_grant_inst;
  assign inst.data_ok = w_inst_data_ok;
  assign inst.rdata   = w_inst_data_ok ? mem.rdata : 32'd0;

  assign data.addr_ok = w_grant_data;
  assign data.data_ok = w_data_data_ok;
  assign data.rdata   = w_data_data_ok ? mem.rdata : 32'd0;

  assign mem.req   = r_mem_req;
  assign mem.wr    = r_wr;
  assign mem.size  = r_size;
  assign mem.wstrb = r_wstrb;
  assign mem.addr  = r_addr;
  assign mem.wdata = r_wdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: one task per scenario with inline
// checks; a second instance runs with STARVE_MAX = 0.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   n_pass = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_rd_if i_if ();
  sram_like_arbiter_if    d_if ();
  sram_like_arbiter_if    m_if ();
  sram_like_arbiter_rd_if i0_if ();
  sram_like_arbiter_if    d0_if ();
  sram_like_arbiter_if    m0_if ();

  sram_like_arbiter #(.STARVE_MAX(4'd3)) dut (
    .clk(clk), .resetn(resetn), .inst(i_if), .data(d_if), .mem(m_if));

  sram_like_arbiter #(.STARVE_MAX(4'd0)) dut0 (
    .clk(clk), .resetn(resetn), .inst(i0_if), .data(d0_if), .mem(m0_if));

  task automatic drive_idle();
    i_if.req = 1'b0;  i_if.addr = 32'd0;
    d_if.req = 1'b0;  d_if.wr = 1'b0; d_if.size = 2'd0; d_if.wstrb = 4'd0;
    d_if.addr = 32'd0; d_if.wdata = 32'd0;
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0; m_if.rdata = 32'd0;
    i0_if.req = 1'b0; i0_if.addr = 32'd0;
    d0_if.req = 1'b0; d0_if.wr = 1'b0; d0_if.size = 2'd0; d0_if.wstrb = 4'd0;
    d0_if.addr = 32'd0; d0_if.wdata = 32'd0;
    m0_if.addr_ok = 1'b0; m0_if.data_ok = 1'b0; m0_if.rdata = 32'd0;
  endtask

  task automatic test_reset();
    drive_idle();
    i_if.req = 1'b1;
    d_if.req = 1'b1;
    #1 resetn = 1'b0;
    #1;
    n_checks++; if (m_if.req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", m_if.req); else n_pass++;
    n_checks++; if ({i_if.addr_ok, d_if.addr_ok} !== 2'b00) $display("FAIL reset_addr_ok got=%b exp=00", {i_if.addr_ok, d_if.addr_ok}); else n_pass++;
    n_checks++; if ({m_if.addr, m_if.wdata, m_if.wstrb} !== 68'd0) $display("FAIL reset_mem_fields got=%h exp=0", {m_if.addr, m_if.wdata, m_if.wstrb}); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    resetn = 1'b1;
  endtask

  task automatic test_single_fetch();
    @(posedge clk); #1;
    i_if.req = 1'b1; i_if.addr = 32'h1c00_0000;
    @(negedge clk);
    n_checks++; if ({i_if.addr_ok, d_if.addr_ok} !== 2'b10) $display("FAIL fetch_addr_ok got=%b exp=10", {i_if.addr_ok, d_if.addr_ok}); else n_pass++;
    @(posedge clk); #1;
    i_if.req = 1'b0; i_if.addr = 32'hffff_ffff; m_if.addr_ok = 1'b1;
    @(negedge clk);
    n_checks++; if ({m_if.req, m_if.wr, m_if.size, m_if.addr} !== {1'b1, 1'b0, 2'd2, 32'h1c00_0000})
      $display("FAIL fetch_mem_cmd got=%h exp=%h", {m_if.req, m_if.wr, m_if.size, m_if.addr}, {1'b1, 1'b0, 2'd2, 32'h1c00_0000}); else n_pass++;
    @(posedge clk); #1;
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'h0280_0c0c;
    @(negedge clk);
    n_checks++; if ({i_if.data_ok, i_if.rdata} !== {1'b1, 32'h0280_0c0c}) $display("FAIL fetch_data got=%h exp=%h", {i_if.data_ok, i_if.rdata}, {1'b1, 32'h0280_0c0c}); else n_pass++;
    n_checks++; if ({d_if.data_ok, d_if.rdata, d_if.addr_ok} !== 34'd0) $display("FAIL fetch_data_side got=%h exp=0", {d_if.data_ok, d_if.rdata, d_if.addr_ok}); else n_pass++;
    @(posedge clk); #1;
    m_if.data_ok = 1'b0;
    @(negedge clk);
    n_checks++; if ({i_if.data_ok, i_if.rdata, m_if.req} !== 34'd0) $display("FAIL fetch_after got=%h exp=0", {i_if.data_ok, i_if.rdata, m_if.req}); else n_pass++;
  endtask

  task automatic test_store_byte();
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    d_if.req = 1'b1; d_if.wr = 1'b1; d_if.size = 2'd0; d_if.wstrb = 4'b0100;
    d_if.addr = 32'h0000_1002; d_if.wdata = 32'h00ab_0000;
    @(negedge clk);
    n_checks++; if ({i_if.addr_ok, d_if.addr_ok} !== 2'b01) $display("FAIL store_addr_ok got=%b exp=01", {i_if.addr_ok, d_if.addr_ok}); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        d_if.req = 1'b0; d_if.wr = 1'b0; d_if.size = 2'd2; d_if.wstrb = 4'hf;
        d_if.addr = 32'hffff_ffff; d_if.wdata = 32'h1234_5678;
      end
      m_if.addr_ok = (k == 3);
      @(negedge clk);
      n_checks++;
      if ({m_if.req, m_if.wr, m_if.size, m_if.wstrb, m_if.addr, m_if.wdata} !== {1'b1, 1'b1, 2'd0, 4'b0100, 32'h0000_1002, 32'h00ab_0000})
        $display("FAIL store_req_hold%0d got=%h exp=%h", k, {m_if.req, m_if.wr, m_if.size, m_if.wstrb, m_if.addr, m_if.wdata},
                 {1'b1, 1'b1, 2'd0, 4'b0100, 32'h0000_1002, 32'h00ab_0000});
      else n_pass++;
    end
    @(posedge clk); #1;
    m_if.addr_ok = 1'b0;
    @(negedge clk);
    n_checks++; if ({m_if.req, d_if.data_ok} !== 2'b00) $display("FAIL store_wait got=%b exp=00", {m_if.req, d_if.data_ok}); else n_pass++;
    @(posedge clk); #1;
    m_if.data_ok = 1'b1; m_if.rdata = 32'h5a5a_5a5a;
    @(negedge clk);
    if (d_if.data_ok === 1'b1) pulses++;
    n_checks++; if ({d_if.data_ok, i_if.data_ok} !== 2'b10) $display("FAIL store_data_ok got=%b exp=10", {d_if.data_ok, i_if.data_ok}); else n_pass++;
    @(posedge clk); #1;
    m_if.data_ok = 1'b0;
    @(negedge clk);
    if (d_if.data_ok === 1'b1) pulses++;
    n_checks++; if (pulses !== 1) $display("FAIL store_pulse_count got=%0d exp=1", pulses); else n_pass++;
  endtask

  task automatic test_contention();
    logic exp_inst;
    @(posedge clk); #1;
    i_if.req = 1'b1; i_if.addr = 32'h1c00_0100;
    d_if.req = 1'b1; d_if.wr = 1'b0; d_if.size = 2'd2; d_if.addr = 32'h0000_2000;
    m_if.addr_ok = 1'b1; m_if.data_ok = 1'b1; m_if.rdata = 32'h1111_2222;
    for (int t = 0; t < 8; t++) begin
      exp_inst = (t == 3) || (t == 7);
      @(negedge clk);
      n_checks++; if ({i_if.addr_ok, d_if.addr_ok} !== {exp_inst, ~exp_inst}) $display("FAIL contend_grant%0d got=%b exp=%b", t, {i_if.addr_ok, d_if.addr_ok}, {exp_inst, ~exp_inst}); else n_pass++;
      if (exp_inst) begin
        n_checks++; if (dut.r_starve_cnt !== 4'd3) $display("FAIL contend_starve_at%0d got=%0d exp=3", t, dut.r_starve_cnt); else n_pass++;
      end
      @(negedge clk);
      if (exp_inst) begin
        n_checks++; if (dut.r_starve_cnt !== 4'd0) $display("FAIL contend_starve_after%0d got=%0d exp=0", t, dut.r_starve_cnt); else n_pass++;
      end
      @(negedge clk);
      n_checks++; if ({i_if.data_ok, d_if.data_ok} !== {exp_inst, ~exp_inst}) $display("FAIL contend_resp%0d got=%b exp=%b", t, {i_if.data_ok, d_if.data_ok}, {exp_inst, ~exp_inst}); else n_pass++;
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    d_if.req = 1'b1; d_if.wr = 1'b0; d_if.size = 2'd2; d_if.addr = 32'h0000_3000;
    @(negedge clk);
    n_checks++; if (d_if.addr_ok !== 1'b1) $display("FAIL arst_accept got=%b exp=1", d_if.addr_ok); else n_pass++;
    @(posedge clk); #1;
    d_if.req = 1'b0; m_if.addr_ok = 1'b1;
    @(posedge clk); #1;
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'hdead_beef;
    #1;
    n_checks++; if (d_if.data_ok !== 1'b1) $display("FAIL arst_pre_data_ok got=%b exp=1", d_if.data_ok); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if ({d_if.data_ok, i_if.data_ok, d_if.addr_ok, i_if.addr_ok, m_if.req, d_if.rdata} !== 37'd0)
      $display("FAIL arst_drop got=%h exp=0", {d_if.data_ok, i_if.data_ok, d_if.addr_ok, i_if.addr_ok, m_if.req, d_if.rdata}); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    d_if.req = 1'b1; d_if.addr = 32'h0000_3004;
    #1;
    n_checks++; if ({d_if.addr_ok, d_if.data_ok} !== 2'b10) $display("FAIL arst_first_accept got=%b exp=10", {d_if.addr_ok, d_if.data_ok}); else n_pass++;
    @(posedge clk); #1;
    d_if.req = 1'b0; m_if.data_ok = 1'b0; m_if.addr_ok = 1'b1;
    @(negedge clk);
    n_checks++; if ({m_if.req, m_if.addr, d_if.data_ok} !== {1'b1, 32'h0000_3004, 1'b0}) $display("FAIL arst_req got=%h exp=%h", {m_if.req, m_if.addr, d_if.data_ok}, {1'b1, 32'h0000_3004, 1'b0}); else n_pass++;
    @(posedge clk); #1;
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'hcafe_0001;
    @(negedge clk);
    n_checks++; if ({d_if.data_ok, d_if.rdata} !== {1'b1, 32'hcafe_0001}) $display("FAIL arst_resp got=%h exp=%h", {d_if.data_ok, d_if.rdata}, {1'b1, 32'hcafe_0001}); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    m_if.data_ok = 1'b1; m_if.rdata = 32'hdead_beef;
    @(negedge clk);
    n_checks++; if ({i_if.data_ok, d_if.data_ok, i_if.rdata, d_if.rdata} !== 66'd0)
      $display("FAIL spurious_ok got=%h exp=0", {i_if.data_ok, d_if.data_ok, i_if.rdata, d_if.rdata}); else n_pass++;
    @(posedge clk); #1;
    m_if.data_ok = 1'b0;
    @(negedge clk);
    n_checks++; if ({dut.r_state, m_if.req} !== 3'd0) $display("FAIL spurious_state got=%h exp=0", {dut.r_state, m_if.req}); else n_pass++;
  endtask

  task automatic test_starve_zero();
    @(posedge clk); #1;
    i0_if.req = 1'b1; i0_if.addr = 32'h1c00_0040;
    d0_if.req = 1'b1; d0_if.addr = 32'h0000_4000; d0_if.size = 2'd2;
    m0_if.addr_ok = 1'b1; m0_if.data_ok = 1'b1; m0_if.rdata = 32'h0000_00aa;
    @(negedge clk);
    n_checks++; if ({i0_if.addr_ok, d0_if.addr_ok} !== 2'b10) $display("FAIL starve0_first got=%b exp=10", {i0_if.addr_ok, d0_if.addr_ok}); else n_pass++;
    @(posedge clk); #1;
    i0_if.req = 1'b0;
    @(negedge clk);
    n_checks++; if ({m0_if.req, m0_if.addr} !== {1'b1, 32'h1c00_0040}) $display("FAIL starve0_req got=%h exp=%h", {m0_if.req, m0_if.addr}, {1'b1, 32'h1c00_0040}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({i0_if.data_ok, i0_if.rdata} !== {1'b1, 32'h0000_00aa}) $display("FAIL starve0_resp got=%h exp=%h", {i0_if.data_ok, i0_if.rdata}, {1'b1, 32'h0000_00aa}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({i0_if.addr_ok, d0_if.addr_ok} !== 2'b01) $display("FAIL starve0_second got=%b exp=01", {i0_if.addr_ok, d0_if.addr_ok}); else n_pass++;
    @(posedge clk); #1;
    d0_if.req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_byte();
    test_contention();
    test_async_reset();
    test_spurious();
    test_starve_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
